// File: rtl/vpu_pkg.sv
// Shared widths, entry record and serializer state encoding for the VPU tensor path.
package vpu_pkg;

  localparam int TENSOR_W = 1024;
  localparam int CHN_W    = 16;
  localparam int TMAX_W   = 16;

  typedef struct packed {
    logic [TMAX_W-1:0]   tmax;
    logic [CHN_W-1:0]    chnaddr;
    logic [TENSOR_W-1:0] tensors;
  } entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/vpu_entry_fifo.sv
// Synchronous entry FIFO with registered pointers; a push into a full FIFO is accepted
// only when the head is popped in the same cycle, otherwise it is dropped and flagged.
module vpu_entry_fifo
  import vpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 wr_entry,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               overflow_reg;
  logic               full;
  logic               pop_ok;
  logic               push_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_reg != '0);
  assign push_ok = push && (!full || pop_ok);

  // Storage carries no reset; the head is only observed while the count is nonzero.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_reg <= count_reg - CNT_W'(1);
      end
      if (push && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign head     = mem_reg[rd_ptr_reg];
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/vpu_tensor_serializer.sv
// Buffers 1024-bit tensor entries and streams each one as LANE_W-bit beats over a
// valid/ready interface, lowest slice first, releasing the entry on its last beat.
module vpu_tensor_serializer
  import vpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LANE_W = 128
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [CHN_W-1:0]                    in_chnaddr,
  input  logic [TMAX_W-1:0]                   in_tmax,
  input  logic [TENSOR_W-1:0]                 in_tensors,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANE_W-1:0]                   out_data,
  output logic [CHN_W-1:0]                    out_chnaddr,
  output logic [TMAX_W-1:0]                   out_tmax,
  output logic [$clog2(TENSOR_W/LANE_W)-1:0]  out_beat,
  output logic                                out_last,
  output logic [$clog2(DEPTH):0]              fifo_count,
  output logic                                overflow
);

  localparam int BEATS  = TENSOR_W / LANE_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  state_e              state_reg;
  logic [BEAT_W-1:0]   beat_reg;
  entry_t              in_entry;
  entry_t              head;
  logic [LANE_W-1:0]   lane [BEATS];
  logic                streaming;
  logic                last_beat;
  logic                xfer;
  logic                pop;

  assign in_entry = '{tmax: in_tmax, chnaddr: in_chnaddr, tensors: in_tensors};

  vpu_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .wr_entry (in_entry),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .overflow (overflow)
  );

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      assign lane[gi] = head.tensors[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign streaming = (state_reg == ST_STREAM);
  assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));
  assign xfer      = streaming && out_ready;
  assign pop       = xfer && last_beat;

  // Entering STREAM on the push edge itself gives beat 0 one cycle after the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          beat_reg <= '0;
          if (in_valid || (fifo_count != '0)) begin
            state_reg <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            beat_reg <= last_beat ? '0 : beat_reg + BEAT_W'(1);
            if (last_beat && (fifo_count == CNT_W'(1)) && !in_valid) begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = streaming;
  assign out_data    = streaming ? lane[beat_reg] : '0;
  assign out_chnaddr = streaming ? head.chnaddr : '0;
  assign out_tmax    = streaming ? head.tmax : '0;
  assign out_beat    = beat_reg;
  assign out_last    = streaming && last_beat;

endmodule

// File: tb/tb_vpu_tensor_serializer.sv
// Scoreboard bench for vpu_tensor_serializer: accepted entries expand into expected beats
// that a negedge monitor pops on every transfer; scenario tasks add targeted checks.
module tb_vpu_tensor_serializer;

  localparam int DEPTH  = 4;
  localparam int LANE_W = 128;
  localparam int BEATS  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic [15:0]    in_chnaddr = '0;
  logic [15:0]    in_tmax = '0;
  logic [1023:0]  in_tensors = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [127:0]   out_data;
  logic [15:0]    out_chnaddr;
  logic [15:0]    out_tmax;
  logic [2:0]     out_beat;
  logic           out_last;
  logic [2:0]     fifo_count;
  logic           overflow;

  always #5 clk = ~clk;

  vpu_tensor_serializer #(.DEPTH(DEPTH), .LANE_W(LANE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_chnaddr  (in_chnaddr),
    .in_tmax     (in_tmax),
    .in_tensors  (in_tensors),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chnaddr (out_chnaddr),
    .out_tmax    (out_tmax),
    .out_beat    (out_beat),
    .out_last    (out_last),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  typedef struct {
    logic [127:0] data;
    logic [15:0]  chn;
    logic [15:0]  tmax;
    logic [2:0]   beat;
    logic         last;
  } beat_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     n_xfer = 0;
  int     n_last = 0;
  beat_t  sb[$];
  int     m_count = 0;
  logic   m_ovf = 1'b0;
  bit     mon_en = 1'b0;
  bit     stall_prev = 1'b0;
  bit     popped;
  beat_t  e;
  beat_t  nb;
  logic [127:0] p_data;
  logic [15:0]  p_chn, p_tmax;
  logic [2:0]   p_beat;

  // Monitor: outputs are stable at negedge, so this is the point where each edge's
  // transfer and push decisions are known.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        sb.delete();
        m_count = 0;
        m_ovf = 1'b0;
        stall_prev = 1'b0;
      end else begin
        popped = 1'b0;
        n_checks++;
        if (out_valid !== (m_count != 0)) begin
          n_errors++;
          $display("FAIL mon_valid: out_valid=%b required=%b", out_valid, (m_count != 0));
        end
        n_checks++;
        if (fifo_count !== m_count[2:0]) begin
          n_errors++;
          $display("FAIL mon_count: fifo_count=%0d required=%0d", fifo_count, m_count);
        end
        n_checks++;
        if (overflow !== m_ovf) begin
          n_errors++;
          $display("FAIL mon_overflow: overflow=%b required=%b", overflow, m_ovf);
        end
        if (stall_prev && out_valid) begin
          n_checks++;
          if (out_data !== p_data || out_chnaddr !== p_chn || out_tmax !== p_tmax || out_beat !== p_beat) begin
            n_errors++;
            $display("FAIL stall_hold: beat=%0d chn=%h data=%h required beat=%0d chn=%h data=%h",
                     out_beat, out_chnaddr, out_data, p_beat, p_chn, p_data);
          end
        end
        if (out_valid && out_ready) begin
          n_xfer++;
          if (out_last) n_last++;
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL beat_unexpected: beat=%0d with empty scoreboard", out_beat);
          end else begin
            e = sb.pop_front();
            if (e.last) popped = 1'b1;
            if (out_data !== e.data) begin
              n_errors++;
              $display("FAIL beat_data: data=%h required=%h", out_data, e.data);
            end
            n_checks++;
            if (out_chnaddr !== e.chn || out_tmax !== e.tmax || out_beat !== e.beat || out_last !== e.last) begin
              n_errors++;
              $display("FAIL beat_meta: chn=%h tmax=%h beat=%0d last=%b required chn=%h tmax=%h beat=%0d last=%b",
                       out_chnaddr, out_tmax, out_beat, out_last, e.chn, e.tmax, e.beat, e.last);
            end
          end
        end
        stall_prev = out_valid && !out_ready;
        p_data = out_data;
        p_chn  = out_chnaddr;
        p_tmax = out_tmax;
        p_beat = out_beat;
        if (in_valid) begin
          if (m_count < DEPTH || popped) begin
            for (int k = 0; k < BEATS; k++) begin
              nb.data = in_tensors[k*LANE_W +: LANE_W];
              nb.chn  = in_chnaddr;
              nb.tmax = in_tmax;
              nb.beat = 3'(k);
              nb.last = (k == BEATS - 1);
              sb.push_back(nb);
            end
            m_count++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (popped) m_count--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rand_tensor();
    logic [1023:0] t;
    for (int i = 0; i < 32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic set_entry(input logic [15:0] chn, input logic [15:0] tmax, input logic [1023:0] t);
    in_valid   = 1'b1;
    in_chnaddr = chn;
    in_tmax    = tmax;
    in_tensors = t;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int guard = 0;
    while (out_valid === 1'b1 && guard < budget) begin
      tick();
      guard++;
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles required 0", name, out_valid, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_entry(16'hDEAD, 16'hBEEF, rand_tensor());
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_last, out_beat, fifo_count, overflow} !== 9'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: valid=%b last=%b beat=%0d count=%0d ovf=%b required all 0",
               out_valid, out_last, out_beat, fifo_count, overflow);
    end
    n_checks++;
    if (out_data !== 128'h0 || out_chnaddr !== 16'h0 || out_tmax !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_data: data=%h chn=%h tmax=%h required 0", out_data, out_chnaddr, out_tmax);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_ignore_in: valid=%b count=%0d required 0 0", out_valid, fifo_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [1023:0] t;
    int x0, l0;
    for (int i = 0; i < 128; i++) t[i*8 +: 8] = 8'(i);
    x0 = n_xfer;
    l0 = n_last;
    out_ready = 1'b1;
    set_entry(16'h0003, 16'h00FF, t);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_beat !== 3'd0 || out_chnaddr !== 16'h0003 || out_tmax !== 16'h00FF) begin
      n_errors++;
      $display("FAIL single_latency: valid=%b beat=%0d chn=%h tmax=%h required 1 0 0003 00ff",
               out_valid, out_beat, out_chnaddr, out_tmax);
    end
    n_checks++;
    if (out_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      n_errors++;
      $display("FAIL single_beat0: data=%h required 0f0e0d0c0b0a09080706050403020100", out_data);
    end
    wait_idle("single", 20);
    n_checks++;
    if (n_xfer - x0 != 8 || n_last - l0 != 1) begin
      n_errors++;
      $display("FAIL single_beats: beats=%0d lasts=%0d required 8 1", n_xfer - x0, n_last - l0);
    end
    $display("test_single done: %0d beats", n_xfer - x0);
  endtask

  task automatic test_stall();
    int x0;
    x0 = n_xfer;
    out_ready = 1'b1;
    set_entry(16'h1234, 16'h5678, rand_tensor());
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && out_valid === 1'b1; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || n_xfer - x0 != 8) begin
      n_errors++;
      $display("FAIL stall_beats: valid=%b beats=%0d required 0 8", out_valid, n_xfer - x0);
    end
    out_ready = 1'b1;
    $display("test_stall done: %0d beats", n_xfer - x0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    set_entry(16'h0A0A, 16'h1111, rand_tensor());
    tick();
    set_entry(16'h0B0B, 16'h2222, rand_tensor());
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_beat !== 3'(i % 8)) begin
        n_errors++;
        $display("FAIL b2b_flow: step=%0d valid=%b beat=%0d required 1 %0d", i, out_valid, out_beat, i % 8);
      end
      if (i == 7 || i == 8) begin
        n_checks++;
        if (out_chnaddr !== (i == 7 ? 16'h0A0A : 16'h0B0B)) begin
          n_errors++;
          $display("FAIL b2b_chn: step=%0d chn=%h required %h", i, out_chnaddr, (i == 7 ? 16'h0A0A : 16'h0B0B));
        end
      end
      tick();
      in_valid = 1'b0;
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_end: out_valid=%b required 0", out_valid);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_entry(16'(16'h0100 + i), 16'(i), rand_tensor());
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_full: count=%0d ovf=%b required 4 1", fifo_count, overflow);
    end
    tick();
    tick();
    out_ready = 1'b1;
    wait_idle("ovf_drain", 60);
    n_checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd0) begin
      n_errors++;
      $display("FAIL ovf_sticky: ovf=%b count=%0d required 1 0", overflow, fifo_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_clear: ovf=%b required 0", overflow);
    end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    int guard = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_entry(16'(16'h0200 + i), 16'(16'h0F00 + i), rand_tensor());
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (out_beat !== 3'd7 && guard < 20) begin
      tick();
      guard++;
    end
    set_entry(16'h0299, 16'h0F99, rand_tensor());
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || out_valid !== 1'b1 || out_beat !== 3'd0) begin
      n_errors++;
      $display("FAIL full_pushpop: count=%0d ovf=%b valid=%b beat=%0d required 4 0 1 0",
               fifo_count, overflow, out_valid, out_beat);
    end
    wait_idle("full_drain", 100);
    $display("test_full_push_pop done");
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_entry(16'(16'h0300 + i), 16'h0123, rand_tensor());
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (out_beat !== 3'd3 && guard < 20) begin
      tick();
      guard++;
    end
    rst = 1'b1;
    set_entry(16'h0399, 16'h0456, rand_tensor());
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || out_beat !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_mid: valid=%b count=%0d ovf=%b beat=%0d required 0 0 0 0",
               out_valid, fifo_count, overflow, out_beat);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_mid_after: valid=%b count=%0d required 0 0", out_valid, fifo_count);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: %0d beats outstanding required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
